// File: rtl/ms_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ms_timer_pkg
// Description : Shared defaults, scheduler state encoding and duration-bus
//               slicing helper for the millisecond timer scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ms_timer_pkg;

    localparam int NCH_DEFAULT = 4;
    localparam int CW_DEFAULT  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } state_e;

    // Bit offset of channel ch's duration field in the flat duration bus
    function automatic int dur_lsb(input int ch, input int cw);
        return ch * cw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ms_timer_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Grants the first requester at or after
//               the pointer; the pointer moves past the winner on advance.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import ms_timer_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req,
    input  logic                     advance,
    output logic [NCH-1:0]           grant,
    output logic [$clog2(NCH)-1:0]   grant_idx
);

    localparam int PW = $clog2(NCH);

    logic [PW-1:0] ptr;
    logic [PW-1:0] pos;

    // Scan from the farthest candidate back to the pointer so the nearest wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        pos       = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            pos = PW'((int'(ptr) + k) % NCH);
            if (req[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                grant_idx  = pos;
            end
        end
    end

    // Pointer moves to the channel after the one just granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ms_timer_sched.sv
`default_nettype none
// ============================================================================
// Module      : ms_timer_sched
// Description : Shares one millisecond tick among NCH one-shot timers. Loads
//               arrive through a req/ack handshake; a sweep FSM decrements
//               every active counter with a single shared decrementer.
// Revision    : 1.0 - initial release
// ============================================================================
module ms_timer_sched
    import ms_timer_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int CW  = CW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_in,
    input  logic [NCH-1:0]      req,
    input  logic [NCH*CW-1:0]   dur,
    input  logic [NCH-1:0]      cancel,
    output logic [NCH-1:0]      ack,
    output logic [NCH-1:0]      busy,
    output logic [NCH-1:0]      done,
    output logic                overrun
);

    localparam int PW = $clog2(NCH);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_LOAD  = LOAD;
    localparam logic [1:0] S_SWEEP = SWEEP;

    logic            tick_s1;
    logic            tick_s2;
    logic            tick_d;
    logic            tick_rise;
    logic            tick_pend;
    logic            enter_sweep;
    logic            load_req;

    logic [1:0]      state;
    logic [PW-1:0]   idx;
    logic [PW-1:0]   gsel;
    logic [NCH-1:0]  grant;
    logic [PW-1:0]   grant_idx;

    logic [CW-1:0]   cnt [NCH];
    logic [NCH-1:0]  active;
    logic [CW-1:0]   dur_ch [NCH];
    logic [CW-1:0]   load_dur;
    logic [CW-1:0]   dec_in;
    logic [CW-1:0]   dec_out;
    logic            dec_last;
    logic            sweep_hit;
    logic            load_now;

    for (genvar i = 0; i < NCH; i++) begin : g_dur
        assign dur_ch[i] = dur[dur_lsb(i, CW) +: CW];
    end

    // Two-flop synchroniser plus edge register on the ms square wave
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_s1 <= 1'b0;
            tick_s2 <= 1'b0;
            tick_d  <= 1'b0;
        end else begin
            tick_s1 <= tick_in;
            tick_s2 <= tick_s1;
            tick_d  <= tick_s2;
        end
    end

    assign tick_rise   = tick_s2 & ~tick_d;
    assign enter_sweep = (state == S_IDLE) && tick_pend;
    assign load_req    = (state == S_IDLE) && !tick_pend && (|req);

    // Pending tick; an edge landing on an unconsumed tick is a lost tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_pend <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            tick_pend <= tick_rise | (tick_pend & ~enter_sweep);
            if (tick_rise && tick_pend && !enter_sweep) begin
                overrun <= 1'b1;
            end
        end
    end

    rr_arbiter #(
        .NCH       (NCH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (load_req),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Scheduler: ticks take priority over loads; a sweep visits each channel once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            gsel  <= '0;
            ack   <= '0;
        end else begin
            ack <= '0;
            case (state)
                S_IDLE: begin
                    if (tick_pend) begin
                        state <= S_SWEEP;
                        idx   <= '0;
                    end else if (|req) begin
                        state <= S_LOAD;
                        gsel  <= grant_idx;
                        ack   <= grant;
                    end
                end
                S_LOAD: begin
                    state <= S_IDLE;
                end
                S_SWEEP: begin
                    if (idx == PW'(NCH - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        idx <= idx + PW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Shared decrementer for the channel under the sweep; never wraps below zero
    assign dec_in    = cnt[idx];
    assign dec_out   = (dec_in == '0) ? '0 : dec_in - CW'(1);
    assign dec_last  = (dec_in == CW'(1));
    assign sweep_hit = (state == S_SWEEP) && active[idx];
    assign load_now  = (state == S_LOAD) && !cancel[gsel];
    assign load_dur  = dur_ch[gsel];

    // Counter array; cancel is applied last so it overrides loads and expiries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
            active <= '0;
            done   <= '0;
        end else begin
            done <= '0;
            if (sweep_hit) begin
                cnt[idx] <= dec_out;
                if (dec_last) begin
                    active[idx] <= 1'b0;
                    done[idx]   <= ~cancel[idx];
                end
            end
            if (load_now) begin
                cnt[gsel]    <= load_dur;
                active[gsel] <= (load_dur != '0);
                done[gsel]   <= (load_dur == '0);
            end
            for (int i = 0; i < NCH; i++) begin
                if (cancel[i]) begin
                    active[i] <= 1'b0;
                end
            end
        end
    end

    assign busy = active;

endmodule
`default_nettype wire
